// File: rtl/gate_prober_pkg.sv
// gate_prober_pkg
//   Shared types and constants for the gate prober.
//   - gate_code_t : classification code for a 4-entry truth table
//   - state_t     : sweep FSM states
//   - TT_*        : truth-table patterns, bit v holds the output for (A,B) = (v[1],v[0])
package gate_prober_pkg;

  typedef enum logic [3:0] {
    GC_CONST0  = 4'h0,
    GC_CONST1  = 4'h1,
    GC_AND     = 4'h2,
    GC_OR      = 4'h3,
    GC_NAND    = 4'h4,
    GC_NOR     = 4'h5,
    GC_XOR     = 4'h6,
    GC_XNOR    = 4'h7,
    GC_BUF_A   = 4'h8,
    GC_NOT_A   = 4'h9,
    GC_BUF_B   = 4'hA,
    GC_NOT_B   = 4'hB,
    GC_UNKNOWN = 4'hF
  } gate_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_CONST0 = 4'b0000;
  localparam logic [3:0] TT_CONST1 = 4'b1111;
  localparam logic [3:0] TT_AND    = 4'b1000;
  localparam logic [3:0] TT_OR     = 4'b1110;
  localparam logic [3:0] TT_NAND   = 4'b0111;
  localparam logic [3:0] TT_NOR    = 4'b0001;
  localparam logic [3:0] TT_XOR    = 4'b0110;
  localparam logic [3:0] TT_XNOR   = 4'b1001;
  localparam logic [3:0] TT_BUF_A  = 4'b1100;
  localparam logic [3:0] TT_NOT_A  = 4'b0011;
  localparam logic [3:0] TT_BUF_B  = 4'b1010;
  localparam logic [3:0] TT_NOT_B  = 4'b0101;

endpackage

// File: rtl/gate_prober_if.sv
// gate_prober_if
//   Control/result bus of the gate prober.
//   start   : begin a sweep (master -> slave)
//   sel_a   : stimulus pin used as operand A
//   sel_b   : stimulus pin used as operand B
//   bkgd    : level of the non-selected stimulus pins
//   ch_sel  : response channel to classify
//   busy    : sweep in progress (slave -> master)
//   done    : one-cycle pulse, ttab valid
//   ttab    : truth tables, 4 bits per response channel
//   gate_cd : gate code of the selected channel
interface gate_prober_if #(
  parameter int N_STIM = 16,
  parameter int N_RESP = 8
);
  logic                  start;
  logic [3:0]            sel_a;
  logic [3:0]            sel_b;
  logic [N_STIM-1:0]     bkgd;
  logic [2:0]            ch_sel;
  logic                  busy;
  logic                  done;
  logic [4*N_RESP-1:0]   ttab;
  logic [3:0]            gate_cd;

  modport master (
    output start, sel_a, sel_b, bkgd, ch_sel,
    input  busy, done, ttab, gate_cd
  );

  modport slave (
    input  start, sel_a, sel_b, bkgd, ch_sel,
    output busy, done, ttab, gate_cd
  );
endinterface

// File: rtl/gate_prober_classifier.sv
// gate_classifier
//   Purely combinational mapping of a 4-entry truth table onto a gate code.
//   tt   : truth table, bit v = output for (A,B) = (v[1],v[0])
//   code : matching gate code, GC_UNKNOWN if no pattern matches
module gate_classifier
  import gate_prober_pkg::*;
(
  input  logic [3:0] tt,
  output gate_code_t code
);

  always_comb begin
    code = GC_UNKNOWN;
    case (tt)
      TT_CONST0: code = GC_CONST0;
      TT_CONST1: code = GC_CONST1;
      TT_AND:    code = GC_AND;
      TT_OR:     code = GC_OR;
      TT_NAND:   code = GC_NAND;
      TT_NOR:    code = GC_NOR;
      TT_XOR:    code = GC_XOR;
      TT_XNOR:   code = GC_XNOR;
      TT_BUF_A:  code = GC_BUF_A;
      TT_NOT_A:  code = GC_NOT_A;
      TT_BUF_B:  code = GC_BUF_B;
      TT_NOT_B:  code = GC_NOT_B;
      default:   code = GC_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/gate_prober.sv
// gate_prober
//   Automatic solver for the logic-gate guessing puzzle. A sweep drives the four
//   (A,B) combinations onto two selected stimulus pins over a latched background
//   pattern, waits SETTLE cycles per vector and records every response channel
//   into a 4-entry truth table. One channel's table is classified into a gate code.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : control/result interface (slave side)
//   stim  : drive to the puzzle inputs
//   resp  : puzzle outputs, asynchronous, synchronised internally
module gate_prober
  import gate_prober_pkg::*;
#(
  parameter int N_STIM = 16,
  parameter int N_RESP = 8,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_prober_if.slave      bus,
  output logic [N_STIM-1:0] stim,
  input  logic [N_RESP-1:0] resp
);

  localparam int CNT_W = $clog2(SETTLE);

  state_t                state;
  logic [CNT_W-1:0]      settle_cnt;
  logic [1:0]            vec_cnt;
  logic [3:0]            sel_a_q;
  logic [3:0]            sel_b_q;
  logic [N_STIM-1:0]     bkgd_q;
  logic                  busy_q;
  logic                  done_q;
  logic [4*N_RESP-1:0]   ttab_q;
  logic [4*N_RESP-1:0]   ttab_next;
  logic [N_RESP-1:0]     resp_sync1;
  logic [N_RESP-1:0]     resp_sync2;
  logic [3:0]            sel_tab;
  gate_code_t            gate_code;

  // Pin B is written first so that when both selects name the same pin,
  // operand A (v[1]) wins.
  function automatic logic [N_STIM-1:0] drive_vec(
    input logic [N_STIM-1:0] bg,
    input logic [3:0]        a,
    input logic [3:0]        b,
    input logic [1:0]        v
  );
    logic [N_STIM-1:0] r;
    r    = bg;
    r[b] = v[0];
    r[a] = v[1];
    return r;
  endfunction

  // Two-flop synchroniser on the asynchronous puzzle outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_sync1 <= '0;
      resp_sync2 <= '0;
    end else begin
      resp_sync1 <= resp;
      resp_sync2 <= resp_sync1;
    end
  end

  // Only the column for the current vector is replaced; the other three
  // columns keep the samples taken earlier in this sweep.
  always_comb begin
    ttab_next = ttab_q;
    for (int ch = 0; ch < N_RESP; ch++) begin
      for (int v = 0; v < 4; v++) begin
        if (vec_cnt == 2'(v)) begin
          ttab_next[4*ch+v] = resp_sync2[ch];
        end
      end
    end
  end

  // Sweep FSM. stim is loaded with the next vector on entry to DRIVE so the
  // puzzle sees it for the full settle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      vec_cnt    <= 2'd0;
      sel_a_q    <= 4'd0;
      sel_b_q    <= 4'd0;
      bkgd_q     <= '0;
      stim       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ttab_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            sel_a_q    <= bus.sel_a;
            sel_b_q    <= bus.sel_b;
            bkgd_q     <= bus.bkgd;
            ttab_q     <= '0;
            vec_cnt    <= 2'd0;
            settle_cnt <= '0;
            stim       <= drive_vec(bus.bkgd, bus.sel_a, bus.sel_b, 2'd0);
            busy_q     <= 1'b1;
            state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (settle_cnt == CNT_W'(SETTLE - 1)) begin
            settle_cnt <= '0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          ttab_q <= ttab_next;
          if (vec_cnt == 2'd3) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            vec_cnt <= vec_cnt + 2'd1;
            stim    <= drive_vec(bkgd_q, sel_a_q, sel_b_q, vec_cnt + 2'd1);
            state   <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel_tab = ttab_q[{bus.ch_sel, 2'b00} +: 4];

  gate_classifier u_classifier (
    .tt   (sel_tab),
    .code (gate_code)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ttab    = ttab_q;
  assign bus.gate_cd = gate_code;

endmodule

// File: tb/tb_gate_prober.sv
// tb_gate_prober
//   Self-checking bench for gate_prober with a behavioural puzzle model wired
//   between stim and resp. Expected truth tables are pushed to a scoreboard at
//   start and popped when done pulses.
module tb_gate_prober;

  logic        clk;
  logic        rst_n;
  logic [15:0] stim;
  logic [7:0]  resp;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_start_cyc = 0;

  typedef struct {
    logic [31:0] ttab;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];

  gate_prober_if #(.N_STIM(16), .N_RESP(8)) bus ();

  gate_prober #(.N_STIM(16), .N_RESP(8), .SETTLE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .stim  (stim),
    .resp  (resp)
  );

  // Puzzle under test: one gate per output channel.
  function automatic logic [7:0] puzzle(input logic [15:0] s);
    logic [7:0] r;
    r[0] = s[0] & s[2];
    r[1] = ~s[1];
    r[2] = s[5] & s[7] & s[10];
    r[3] = s[3] | s[12];
    r[4] = ~(s[4] & s[9]);
    r[5] = ~(s[8] ^ s[11]);
    r[6] = ~(s[14] | s[15]);
    r[7] = s[6] ^ s[13];
    return r;
  endfunction

  assign resp = puzzle(stim);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [15:0] tb_vec(input logic [15:0] bg, input logic [3:0] a,
                                         input logic [3:0] b, input logic [1:0] v);
    logic [15:0] r;
    r    = bg;
    r[b] = v[0];
    r[a] = v[1];
    return r;
  endfunction

  function automatic logic [31:0] tb_ttab(input logic [15:0] bg, input logic [3:0] a,
                                          input logic [3:0] b);
    logic [31:0] t;
    logic [7:0]  r;
    t = '0;
    for (int v = 0; v < 4; v++) begin
      r = puzzle(tb_vec(bg, a, b, 2'(v)));
      for (int ch = 0; ch < 8; ch++) t[4*ch+v] = r[ch];
    end
    return t;
  endfunction

  function automatic logic [3:0] tb_code(input logic [3:0] t);
    case (t)
      4'b0000: return 4'h0;
      4'b1111: return 4'h1;
      4'b1000: return 4'h2;
      4'b1110: return 4'h3;
      4'b0111: return 4'h4;
      4'b0001: return 4'h5;
      4'b0110: return 4'h6;
      4'b1001: return 4'h7;
      4'b1100: return 4'h8;
      4'b0011: return 4'h9;
      4'b1010: return 4'hA;
      4'b0101: return 4'hB;
      default: return 4'hF;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses start for one cycle; returns at the negedge of cycle 1.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [15:0] bg, input bit track);
    exp_t e;
    @(negedge clk);
    bus.sel_a = a;
    bus.sel_b = b;
    bus.bkgd  = bg;
    bus.start = 1'b1;
    last_start_cyc = cyc;
    if (track) begin
      e.ttab      = tb_ttab(bg, a, b);
      e.start_cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy_cycle1", 32'(bus.busy), 32'd1);
    checkOutput("stim_vec0", 32'(stim), 32'(tb_vec(bg, a, b, 2'd0)));
  endtask

  task automatic waitDone(output logic [31:0] exp_ttab);
    int   n;
    exp_t e;
    n = 0;
    exp_ttab = '0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < 100);
    if (bus.done !== 1'b1) begin
      checkOutput("done_timeout", 32'(bus.done), 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      checkOutput("sb_size", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        exp_ttab = e.ttab;
        checkOutput("done_latency", 32'(cyc - e.start_cyc), 32'd21);
        checkOutput("ttab", bus.ttab, e.ttab);
        checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  endtask

  task automatic checkGateCodes(input logic [31:0] exp_ttab);
    for (int ch = 0; ch < 8; ch++) begin
      bus.ch_sel = 3'(ch);
      #1;
      checkOutput($sformatf("gate_cd_ch%0d", ch), 32'(bus.gate_cd),
                  32'(tb_code(exp_ttab[4*ch +: 4])));
    end
  endtask

  task automatic checkChannel(input string tag, input logic [2:0] ch,
                              input logic [3:0] tt, input logic [3:0] code);
    bus.ch_sel = ch;
    #1;
    checkOutput({tag, "_tt"}, 32'(bus.ttab[{ch, 2'b00} +: 4]), 32'(tt));
    checkOutput({tag, "_cd"}, 32'(bus.gate_cd), 32'(code));
  endtask

  initial begin
    logic [31:0] exp_tt;
    logic [31:0] first_tt;
    int          d0;

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.sel_a  = 4'd0;
    bus.sel_b  = 4'd0;
    bus.bkgd   = 16'h0;
    bus.ch_sel = 3'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_stim", 32'(stim), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_ttab", bus.ttab, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // AND on channel 0
    applyStimulus(4'd0, 4'd2, 16'h0000, 1'b1);
    waitDone(first_tt);
    checkGateCodes(first_tt);
    checkChannel("and_ch0", 3'd0, 4'b1000, 4'h2);
    repeat (5) @(negedge clk);
    checkOutput("ttab_hold", bus.ttab, first_tt);

    // NAND on channel 4
    applyStimulus(4'd4, 4'd9, 16'h0000, 1'b1);
    waitDone(exp_tt);
    checkGateCodes(exp_tt);
    checkChannel("nand_ch4", 3'd4, 4'b0111, 4'h4);

    // NOR on channel 6, XNOR on channel 5
    applyStimulus(4'd14, 4'd15, 16'h0000, 1'b1);
    waitDone(exp_tt);
    checkChannel("nor_ch6", 3'd6, 4'b0001, 4'h5);
    applyStimulus(4'd8, 4'd11, 16'h0000, 1'b1);
    waitDone(exp_tt);
    checkGateCodes(exp_tt);
    checkChannel("xnor_ch5", 3'd5, 4'b1001, 4'h7);

    // Three-input channel 2: third input comes from the background
    applyStimulus(4'd5, 4'd7, 16'h0400, 1'b1);
    waitDone(exp_tt);
    checkChannel("and3_bg1", 3'd2, 4'b1000, 4'h2);
    applyStimulus(4'd5, 4'd7, 16'h0000, 1'b1);
    waitDone(exp_tt);
    checkChannel("and3_bg0", 3'd2, 4'b0000, 4'h0);

    // Same pin for A and B: A wins
    applyStimulus(4'd1, 4'd1, 16'h0000, 1'b1);
    waitDone(exp_tt);
    checkChannel("same_pin", 3'd1, 4'b0011, 4'h9);

    // OR, XOR, buffers and inverters spread over the channels
    applyStimulus(4'd3, 4'd12, 16'h0000, 1'b1);
    waitDone(exp_tt);
    checkGateCodes(exp_tt);
    checkChannel("or_ch3", 3'd3, 4'b1110, 4'h3);
    applyStimulus(4'd6, 4'd13, 16'h0000, 1'b1);
    waitDone(exp_tt);
    checkChannel("xor_ch7", 3'd7, 4'b0110, 4'h6);
    applyStimulus(4'd0, 4'd3, 16'h0004, 1'b1);
    waitDone(exp_tt);
    checkGateCodes(exp_tt);
    checkChannel("buf_a", 3'd0, 4'b1100, 4'h8);
    checkChannel("buf_b", 3'd3, 4'b1010, 4'hA);
    applyStimulus(4'd2, 4'd1, 16'h0000, 1'b1);
    waitDone(exp_tt);
    checkChannel("not_b", 3'd1, 4'b0101, 4'hB);

    // start re-pulsed and sel_a changed mid-sweep: no effect
    d0 = done_cnt;
    applyStimulus(4'd0, 4'd2, 16'h0000, 1'b1);
    while (cyc < last_start_cyc + 8) @(negedge clk);
    bus.start = 1'b1;
    bus.sel_a = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(exp_tt);
    checkOutput("repulse_ttab", bus.ttab, first_tt);
    repeat (30) @(negedge clk);
    checkOutput("repulse_one_done", 32'(done_cnt - d0), 32'd1);

    // Reset mid-sweep
    d0 = done_cnt;
    applyStimulus(4'd4, 4'd9, 16'h0000, 1'b0);
    while (cyc < last_start_cyc + 10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_stim", 32'(stim), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_ttab", bus.ttab, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("midrst_idle_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
